// File: rtl/duckcpu_uart_pkg.sv
// Shared UART definitions for the duckcpu bootloader path.
// Holds the divider width, the common 115200-baud divider value and the
// receiver state encoding (3-bit values for legacy-compatible compares).
package duckcpu_uart_pkg;

  localparam int UART_DIV_W            = 12;
  localparam int UART_DIV_115200_50MHZ = 434;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE      = 3'd0;
  localparam rx_state_t RX_START     = 3'd1;
  localparam rx_state_t RX_DATA      = 3'd2;
  localparam rx_state_t RX_STOP      = 3'd3;
  localparam rx_state_t RX_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake between the UART receiver and its consumer.
//   data_rx      : last received byte (receiver -> consumer)
//   have_data_rx : byte valid, held until acknowledged (receiver -> consumer)
//   data_rx_ack  : consumer acknowledge, pulse or level (consumer -> receiver)
interface uart_rx_if;
  logic [7:0] data_rx;
  logic       have_data_rx;
  logic       data_rx_ack;

  modport master (output data_rx, output have_data_rx, input data_rx_ack);
  modport slave  (input data_rx, input have_data_rx, output data_rx_ack);
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Flops reset to 1 so an idle-high line does not look active after reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output, DEPTH cycles behind d
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {DEPTH{1'b1}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding the bootloader.
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : receiver enable; low returns the FSM to IDLE
//   divider        : clocks per bit, latched at start of each frame
//   rx             : asynchronous serial input, idle high
//   rx_bus         : byte/have-data/ack handshake (master side)
//   framing_error  : 1-cycle pulse when the stop bit is sampled low
//   overrun        : sticky, a byte landed while the previous one was unread
//   busy           : FSM not in IDLE
module uart_rx
  import duckcpu_uart_pkg::*;
#(
  parameter int DIV_W       = UART_DIV_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] divider,
  input  logic             rx,
  uart_rx_if.master        rx_bus,
  output logic             framing_error,
  output logic             overrun,
  output logic             busy
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic             rx_s;
  rx_state_t        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             have_q, have_d;
  logic             fe_q, fe_d;
  logic             ovr_q, ovr_d;
  logic             tick;
  logic             commit;
  logic             ack;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign tick = (cnt_q == '0);
  assign ack  = rx_bus.data_rx_ack;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q - CNT_ONE;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    have_d    = have_q;
    fe_d      = 1'b0;
    ovr_d     = ovr_q;
    commit    = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (enable && !rx_s) begin
          // Half-bit wait so later samples land mid-bit.
          div_d   = divider;
          cnt_d   = (divider >> 1) - CNT_ONE;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = RX_IDLE;  // glitch, not a real start bit
          end else begin
            cnt_d     = div_q - CNT_ONE;
            bit_idx_d = 3'd0;
            state_d   = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = div_q - CNT_ONE;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          cnt_d = div_q - CNT_ONE;
          if (rx_s) begin
            commit  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            fe_d    = 1'b1;
            // Hold off until the line recovers so a break is not
            // mistaken for a stream of start bits.
            state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (!enable) begin
      state_d = RX_IDLE;
      commit  = 1'b0;
      fe_d    = 1'b0;
    end

    if (ack && have_q) begin
      have_d = 1'b0;
      ovr_d  = 1'b0;
    end
    // A new byte overrides a same-cycle ack; overrun only if the old byte
    // was genuinely left unread.
    if (commit) begin
      data_d = shreg_q;
      have_d = 1'b1;
      if (have_q && !ack) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      have_q    <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      have_q    <= have_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_bus.data_rx      = data_q;
  assign rx_bus.have_data_rx = have_q;
  assign framing_error       = fe_q;
  assign overrun             = ovr_q;
  assign busy                = (state_q != RX_IDLE);

endmodule
